// File: rtl/cix32_muldiv_iter.sv
// CIX-32 iterative multiply/divide unit (MUL/IMUL/DIV/IDIV, three sizes).
// Radix-2^MBITS shift-add multiply, restoring divide on magnitudes, #DE detect.
module cix32_muldiv_iter #(
  parameter int W     = 32,
  parameter int MBITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [1:0]   size,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] op_high,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result_lo,
  output logic [W-1:0] result_hi,
  output logic         cf,
  output logic         of,
  output logic         div_error
);

  localparam int Q  = W / 4;
  localparam int H  = W / 2;
  localparam int CW = $clog2(W + 1);
  localparam int NM = W / MBITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [1:0]     op_r;
  logic [CW-1:0]  sw_r;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] aux;
  logic [W-1:0]   b_r;
  logic           neg1;
  logic           neg2;
  logic           ovf_r;

  logic           accept;
  logic [1:0]     sz_in;
  logic           sgn_in;
  logic [CW-1:0]  sw_in;
  logic [W-1:0]   a_x, b_x;
  logic [2*W-1:0] d_x;
  logic           neg_a, neg_b, neg_d;
  logic [W-1:0]   a_m, b_m;
  logic [2*W-1:0] d_m;
  logic [2*W-1:0] vsh;
  logic           hi_ge;
  logic           b_zero;
  logic           de_now;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign of        = cf;
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    sz_in  = (size == 2'b11) ? 2'b10 : size;
    sgn_in = op[0];
    sw_in  = CW'(W);
    a_x    = op_a;
    b_x    = op_b;
    d_x    = {op_high, op_a};
    unique case (1'b1)
      (sz_in == 2'b00): begin
        sw_in = CW'(Q);
        a_x = {{(W-Q){sgn_in & op_a[Q-1]}}, op_a[Q-1:0]};
        b_x = {{(W-Q){sgn_in & op_b[Q-1]}}, op_b[Q-1:0]};
        d_x = {{(2*W-2*Q){sgn_in & op_high[Q-1]}},
               op_high[Q-1:0], op_a[Q-1:0]};
      end
      (sz_in == 2'b01): begin
        sw_in = CW'(H);
        a_x = {{(W-H){sgn_in & op_a[H-1]}}, op_a[H-1:0]};
        b_x = {{(W-H){sgn_in & op_b[H-1]}}, op_b[H-1:0]};
        d_x = {{(2*W-2*H){sgn_in & op_high[H-1]}},
               op_high[H-1:0], op_a[H-1:0]};
      end
      default: ;
    endcase
  end

  assign neg_a  = sgn_in & a_x[W-1];
  assign neg_b  = sgn_in & b_x[W-1];
  assign neg_d  = sgn_in & d_x[2*W-1];
  assign a_m    = neg_a ? -a_x : a_x;
  assign b_m    = neg_b ? -b_x : b_x;
  assign d_m    = neg_d ? -d_x : d_x;
  assign vsh    = {{W{1'b0}}, b_m} << sw_in;
  assign hi_ge  = (d_m >= vsh);
  assign b_zero = (b_m == '0);
  // Zero divisor always faults; unsigned overflow is visible up front
  assign de_now = op[1] && (b_zero || (!op[0] && hi_ge));

  logic [2*W-1:0] mul_sum;
  always_comb begin
    mul_sum = acc;
    for (int j = 0; j < MBITS; j++)
      if (b_r[j]) mul_sum = mul_sum + (aux << j);
  end

  logic [W:0] dv_t, dv_d;
  logic       dv_ge;
  assign dv_t  = {acc[2*W-1:W], acc[W-1]};
  assign dv_ge = (dv_t >= {1'b0, aux[W-1:0]});
  assign dv_d  = dv_t - {1'b0, aux[W-1:0]};

  logic [W-1:0]   mask;
  logic [2*W-1:0] p_s, p_hi;
  logic [W-1:0]   q_s, r_s, lim;
  logic           sbit;
  logic [W-1:0]   fx_lo, fx_hi;
  logic           fx_cf, fx_de;

  always_comb begin
    mask  = ~({W{1'b1}} << sw_r);
    p_s   = neg1 ? -acc : acc;
    p_hi  = p_s >> sw_r;
    q_s   = neg1 ? -acc[W-1:0] : acc[W-1:0];
    r_s   = neg2 ? -acc[2*W-1:W] : acc[2*W-1:W];
    lim   = (mask >> 1) + W'(neg1);
    sbit  = 1'b0;
    fx_lo = '0;
    fx_hi = '0;
    fx_cf = 1'b0;
    fx_de = 1'b0;
    if (!op_r[1]) begin
      fx_lo = p_s[W-1:0] & mask;
      fx_hi = p_hi[W-1:0] & mask;
      sbit  = |(fx_lo & (mask ^ (mask >> 1)));
      if (op_r[0]) fx_cf = (fx_hi != (sbit ? mask : '0));
      else         fx_cf = (fx_hi != '0);
    end else begin
      fx_de = op_r[0] && (ovf_r || (acc[W-1:0] > lim));
      if (!fx_de) begin
        fx_lo = q_s & mask;
        fx_hi = r_s & mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (accept) begin
          if (!op[1])      state_n = S_MUL;
          else if (de_now) state_n = S_DONE;
          else             state_n = S_DIV;
        end
      S_MUL:  if (cnt == '0) state_n = S_FIX;
      S_DIV:  if (cnt == '0) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= '0;
      sw_r      <= '0;
      cnt       <= '0;
      acc       <= '0;
      aux       <= '0;
      b_r       <= '0;
      neg1      <= 1'b0;
      neg2      <= 1'b0;
      ovf_r     <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      cf        <= 1'b0;
      div_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (accept) begin
            op_r  <= op;
            sw_r  <= sw_in;
            neg2  <= neg_d;
            ovf_r <= hi_ge;
            b_r   <= b_m;
            if (!op[1]) begin
              acc  <= '0;
              aux  <= {{W{1'b0}}, a_m};
              cnt  <= CW'(NM - 1);
              neg1 <= neg_a ^ neg_b;
            end else begin
              acc  <= d_m;
              aux  <= {{W{1'b0}}, b_m};
              cnt  <= CW'(W - 1);
              neg1 <= neg_d ^ neg_b;
            end
            if (de_now) begin
              result_lo <= '0;
              result_hi <= '0;
              cf        <= 1'b0;
              div_error <= 1'b1;
            end
          end
        S_MUL: begin
          acc <= mul_sum;
          aux <= aux << MBITS;
          b_r <= b_r >> MBITS;
          cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          acc <= {dv_ge ? dv_d[W-1:0] : dv_t[W-1:0],
                  acc[W-2:0], dv_ge};
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          result_lo <= fx_lo;
          result_hi <= fx_hi;
          cf        <= fx_cf;
          div_error <= fx_de;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cix32_muldiv_iter.md
Name: cix32_muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the CIX-32 execute stage.
- Executes MUL, IMUL, DIV and IDIV at three operand sizes: W, W/2 and W/4 (8/16/32 at the default W).
- Uses a valid/ready handshake on both input and output, a configurable multiply radix, x86-style #DE detection for divide-by-zero and quotient overflow, and a pipeline flush.
- Sits beside the ALU. Results return to the writeback mux, and div_error goes to the exception unit.

Parameters:
W, 32, full operand width; must be a multiple of 4 and at least 8.
MBITS, 2, multiplier bits retired per MUL cycle; must be 1, 2 or 4, and W must be divisible by MBITS.

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
flush  in  1  synchronous abort of any operation in flight
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
op  in  2  00 MUL, 01 IMUL, 10 DIV, 11 IDIV
size  in  2  00 W/4, 01 W/2, 10 W; 11 is reserved and treated as 10
op_a  in  W  multiplicand, or dividend low half
op_b  in  W  multiplier, or divisor
op_high  in  W  dividend high half (divide only)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result_lo  out  W  product low S bits or quotient, zero-extended to W
result_hi  out  W  product high S bits or remainder, zero-extended to W
cf  out  1  multiply overflow flag
of  out  1  equal to cf
div_error  out  1  #DE; qualified by out_valid

Behaviour:
- Sizing: S denotes the selected size. Only bits [S-1:0] of op_a, op_b and op_high are used. The dividend is {op_high[S-1:0], op_a[S-1:0]}, 2S bits wide.
- Reset values:
  - state IDLE; in_ready=1.
  - out_valid, result_lo, result_hi, cf, of, div_error all 0.
- Accept: a request is accepted when in_valid && in_ready && !flush. At accept, operands, op and size are captured; later input changes are ignored.
- in_ready is 1 only in IDLE.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE transitions on accept:
  - op is MUL/IMUL -> MUL.
  - op is DIV/IDIV with divisor[S-1:0]==0 -> DONE with div_error=1. out_valid asserts 1 cycle after accept.
  - unsigned DIV with op_high[S-1:0] >= op_b[S-1:0] -> DONE with div_error=1 (quotient overflow).
  - any other divide -> DIV.
- MUL state:
  - Retires MBITS multiplier bits per cycle, always for exactly W/MBITS cycles regardless of size.
  - Signed operands are sign-extended from S. Then -> FIX.
- DIV state:
  - Restoring division on operand magnitudes, one quotient bit per cycle, exactly W cycles.
  - Narrow sizes are pre-aligned so that W iterations are correct. Then -> FIX.
- FIX state (1 cycle):
  - Applies signs. The quotient is truncated toward zero; the remainder takes the dividend's sign.
  - IDIV: if the signed quotient is outside [-2^(S-1), 2^(S-1)-1], set div_error=1.
  - Computes flags, registers the outputs, then -> DONE.
- Latency from the accept cycle to out_valid:
  - MUL/IMUL: W/MBITS+2 cycles.
  - Divide (non-error): W+2 cycles.
  - #DE detected in IDLE: 1 cycle.
- DONE state:
  - out_valid=1; all outputs are held stable until out_valid && out_ready.
  - Next cycle -> IDLE with out_valid=0.
  - No new request is accepted in DONE.
- Flags:
  - MUL: cf=of=(hi != 0).
  - IMUL: cf=of=(hi != sign-extension of lo[S-1]).
  - Divide: cf=of=0.
- On div_error: result_lo and result_hi are 0.
- Flush:
  - Any state -> IDLE on the next edge; out_valid=0 and no result is delivered.
  - Flush in the same cycle as in_valid blocks the accept.
  - Flush in the same cycle as an out_ready handshake: the result counts as consumed.
- Reset mid-operation: immediate return to reset values; no partial result is visible.
- Timing: outputs are registered. in_ready and out_valid are decoded from state only and must not combinationally depend on in_valid or out_ready.

Test Plan:
1. W=32, MBITS=2: MUL size=10, op_a=op_b=0xFFFFFFFF -> out_valid at accept+18; result_hi=0xFFFFFFFE, result_lo=0x00000001, cf=of=1.
2. IMUL size=00, op_a=0xFD (-3), op_b=0x05 -> result_lo=0x000000F1, result_hi=0x000000FF, cf=of=0. Then 0x40*0x02 -> result_lo=0x80, result_hi=0x00, cf=of=1.
3. IDIV size=01, op_high=0xFFFF, op_a=0xFFF9 (-7), op_b=0x0002 -> at accept+34: result_lo=0xFFFD, result_hi=0xFFFF, div_error=0. DIV size=10, {1, 0} / 3 -> q=0x55555555, r=1.
4. #DE cases, each with div_error=1 and results 0:
   - DIV op_b=0 -> out_valid at accept+1.
   - DIV size=10, op_high=2, op_b=2 -> out_valid at accept+1.
   - IDIV size=00, op_high=0xFF, op_a=0x80, op_b=0xFF (-128/-1) -> out_valid at accept+34.
5. Backpressure: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout. Release -> out_valid drops and in_ready rises the following cycle. Back-to-back requests complete correctly.
6. Flush mid-DIV at accept+10 -> next cycle IDLE, in_ready=1, no out_valid. Async rst_n pulse mid-MUL -> all outputs read reset values immediately. The next request yields a correct result.
